// File: rtl/cpu_rf_wr_arb.sv
// Register-file write-port arbiter: two one-entry request buffers, round-robin
// grant into a registered write stage, plus read-after-write hazard flags.
module cpu_rf_wr_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_vld,
    input  logic [ADDR_W-1:0] req0_sel,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_rdy,
    input  logic              req1_vld,
    input  logic [ADDR_W-1:0] req1_sel,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_rdy,
    output logic              rf_wrt_en,
    output logic [ADDR_W-1:0] rf_wrt_sel,
    output logic [DATA_W-1:0] rf_wrt_data,
    input  logic [ADDR_W-1:0] rd_sel1,
    input  logic [ADDR_W-1:0] rd_sel2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              gnt_src
);

    logic              buf0_vld, buf1_vld;
    logic [ADDR_W-1:0] buf0_sel, buf1_sel;
    logic [DATA_W-1:0] buf0_data, buf1_data;
    logic              ptr;

    logic              gnt_vld;
    logic              gnt_idx;
    logic              grant0, grant1;
    logic              load0, load1;

    // ptr only breaks ties; a lone valid buffer always wins.
    always_comb begin
        gnt_vld = buf0_vld | buf1_vld;
        gnt_idx = 1'b0;
        if (buf0_vld && buf1_vld) begin
            gnt_idx = ptr;
        end else if (buf1_vld) begin
            gnt_idx = 1'b1;
        end
    end

    assign grant0 = gnt_vld & ~gnt_idx;
    assign grant1 = gnt_vld & gnt_idx;

    assign req0_rdy = ~rst & (~buf0_vld | grant0);
    assign req1_rdy = ~rst & (~buf1_vld | grant1);

    assign load0 = req0_vld & req0_rdy;
    assign load1 = req1_vld & req1_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_vld    <= 1'b0;
            buf0_sel    <= '0;
            buf0_data   <= '0;
            buf1_vld    <= 1'b0;
            buf1_sel    <= '0;
            buf1_data   <= '0;
            ptr         <= 1'b0;
            rf_wrt_en   <= 1'b0;
            rf_wrt_sel  <= '0;
            rf_wrt_data <= '0;
            gnt_src     <= 1'b0;
        end else begin
            // A reload on the draining edge takes precedence over the clear.
            if (load0) begin
                buf0_vld  <= 1'b1;
                buf0_sel  <= req0_sel;
                buf0_data <= req0_data;
            end else if (grant0) begin
                buf0_vld  <= 1'b0;
            end

            if (load1) begin
                buf1_vld  <= 1'b1;
                buf1_sel  <= req1_sel;
                buf1_data <= req1_data;
            end else if (grant1) begin
                buf1_vld  <= 1'b0;
            end

            if (gnt_vld) begin
                rf_wrt_en   <= 1'b1;
                rf_wrt_sel  <= gnt_idx ? buf1_sel  : buf0_sel;
                rf_wrt_data <= gnt_idx ? buf1_data : buf0_data;
                gnt_src     <= gnt_idx;
                ptr         <= ~gnt_idx;
            end else begin
                rf_wrt_en   <= 1'b0;
            end
        end
    end

    // Any write not yet captured by the register file makes a read stale.
    always_comb begin
        hazard1 = (buf0_vld  && (buf0_sel   == rd_sel1)) ||
                  (buf1_vld  && (buf1_sel   == rd_sel1)) ||
                  (rf_wrt_en && (rf_wrt_sel == rd_sel1));
        hazard2 = (buf0_vld  && (buf0_sel   == rd_sel2)) ||
                  (buf1_vld  && (buf1_sel   == rd_sel2)) ||
                  (rf_wrt_en && (rf_wrt_sel == rd_sel2));
    end

endmodule

// File: tb/tb_cpu_rf_wr_arb.sv
// Directed self-checking bench for cpu_rf_wr_arb with hand-computed expectations.
module tb_cpu_rf_wr_arb;

    logic        clk;
    logic        rst;
    logic        req0_vld, req1_vld;
    logic [3:0]  req0_sel, req1_sel;
    logic [31:0] req0_data, req1_data;
    logic        req0_rdy, req1_rdy;
    logic        rf_wrt_en;
    logic [3:0]  rf_wrt_sel;
    logic [31:0] rf_wrt_data;
    logic [3:0]  rd_sel1, rd_sel2;
    logic        hazard1, hazard2;
    logic        gnt_src;

    logic [31:0] rf_model [16];
    int          checks;
    int          errors;

    cpu_rf_wr_arb #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_vld    (req0_vld),
        .req0_sel    (req0_sel),
        .req0_data   (req0_data),
        .req0_rdy    (req0_rdy),
        .req1_vld    (req1_vld),
        .req1_sel    (req1_sel),
        .req1_data   (req1_data),
        .req1_rdy    (req1_rdy),
        .rf_wrt_en   (rf_wrt_en),
        .rf_wrt_sel  (rf_wrt_sel),
        .rf_wrt_data (rf_wrt_data),
        .rd_sel1     (rd_sel1),
        .rd_sel2     (rd_sel2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .gnt_src     (gnt_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in register file fed by the write port.
    always @(posedge clk) begin
        if (rf_wrt_en) rf_model[rf_wrt_sel] <= rf_wrt_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [3:0] s0, input logic [31:0] d0,
                                 input logic v1, input logic [3:0] s1, input logic [31:0] d1);
        req0_vld  = v0;
        req0_sel  = s0;
        req0_data = d0;
        req1_vld  = v1;
        req1_sel  = s1;
        req1_data = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) rf_model[i] = 32'h0;
        rst     = 1'b1;
        rd_sel1 = 4'h0;
        rd_sel2 = 4'h0;
        applyStimulus(1'b1, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);

        // Reset held two cycles with req0 asking
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_rdy0", 32'(req0_rdy), 32'd0);
            checkOutput("rst_rdy1", 32'(req1_rdy), 32'd0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("rel_rdy0", 32'(req0_rdy), 32'd1);
        checkOutput("rel_rdy1", 32'(req1_rdy), 32'd1);
        checkOutput("rst_en", 32'(rf_wrt_en), 32'd0);
        checkOutput("rst_sel", 32'(rf_wrt_sel), 32'd0);
        checkOutput("rst_data", rf_wrt_data, 32'd0);
        checkOutput("rst_src", 32'(gnt_src), 32'd0);
        checkOutput("rst_haz1", 32'(hazard1), 32'd0);
        checkOutput("rst_haz2", 32'(hazard2), 32'd0);

        // Single uncontended write
        rd_sel1 = 4'h3;
        applyStimulus(1'b1, 4'h3, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0);
        step();
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("sw_en_k", 32'(rf_wrt_en), 32'd0);
        checkOutput("sw_haz1_k", 32'(hazard1), 32'd1);
        checkOutput("sw_haz2_k", 32'(hazard2), 32'd0);
        step();
        @(negedge clk);
        checkOutput("sw_en", 32'(rf_wrt_en), 32'd1);
        checkOutput("sw_sel", 32'(rf_wrt_sel), 32'h3);
        checkOutput("sw_data", rf_wrt_data, 32'hDEADBEEF);
        checkOutput("sw_src", 32'(gnt_src), 32'd0);
        checkOutput("sw_haz1", 32'(hazard1), 32'd1);
        step();
        @(negedge clk);
        checkOutput("sw_en_done", 32'(rf_wrt_en), 32'd0);
        checkOutput("sw_haz1_done", 32'(hazard1), 32'd0);
        checkOutput("sw_rf3", rf_model[3], 32'hDEADBEEF);

        // Contention: both requesters valid every cycle
        step();
        applyReset();
        rd_sel1 = 4'h1;
        rd_sel2 = 4'h2;
        applyStimulus(1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'h22);
        for (int i = 1; i <= 6; i++) begin
            step();
            @(negedge clk);
            checkOutput($sformatf("ct_rdy0_%0d", i), 32'(req0_rdy), 32'(i % 2));
            checkOutput($sformatf("ct_rdy1_%0d", i), 32'(req1_rdy), 32'((i + 1) % 2));
            if (i >= 2) begin
                checkOutput($sformatf("ct_en_%0d", i), 32'(rf_wrt_en), 32'd1);
                checkOutput($sformatf("ct_src_%0d", i), 32'(gnt_src), 32'(i % 2));
                checkOutput($sformatf("ct_data_%0d", i), rf_wrt_data, (i % 2 == 1) ? 32'h22 : 32'h11);
            end
        end
        checkOutput("ct_haz1", 32'(hazard1), 32'd1);
        checkOutput("ct_haz2", 32'(hazard2), 32'd1);

        // Same-register collision: req1 first, req0 one cycle later
        step();
        applyReset();
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 4'h5, 32'hAAAA);
        step();
        applyStimulus(1'b1, 4'h5, 32'hBBBB, 1'b0, 4'h0, 32'h0);
        step();
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("col_src1", 32'(gnt_src), 32'd1);
        checkOutput("col_data1", rf_wrt_data, 32'hAAAA);
        step();
        @(negedge clk);
        checkOutput("col_src2", 32'(gnt_src), 32'd0);
        checkOutput("col_data2", rf_wrt_data, 32'hBBBB);
        step();
        step();
        @(negedge clk);
        checkOutput("col_rf5", rf_model[5], 32'hBBBB);

        // Back-to-back solo stream from req1
        step();
        applyReset();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 4'(i), 32'h100 + 32'(i));
            else       applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
            @(negedge clk);
            if (i < 8) checkOutput($sformatf("bb_rdy1_%0d", i), 32'(req1_rdy), 32'd1);
            if (i >= 2) begin
                checkOutput($sformatf("bb_en_%0d", i), 32'(rf_wrt_en), 32'd1);
                checkOutput($sformatf("bb_sel_%0d", i), 32'(rf_wrt_sel), 32'(i - 2));
                checkOutput($sformatf("bb_src_%0d", i), 32'(gnt_src), 32'd1);
            end
            step();
        end
        @(negedge clk);
        checkOutput("bb_en_end", 32'(rf_wrt_en), 32'd0);
        checkOutput("bb_rf7", rf_model[7], 32'h107);

        // Reset mid-flight with ptr pointing at req1 and both buffers full
        step();
        applyReset();
        rd_sel1 = 4'h6;
        rd_sel2 = 4'h7;
        applyStimulus(1'b1, 4'h6, 32'h66, 1'b0, 4'h0, 32'h0);
        step();
        applyStimulus(1'b1, 4'h6, 32'h67, 1'b1, 4'h7, 32'h77);
        step();
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mf_rdy0_rst", 32'(req0_rdy), 32'd0);
        checkOutput("mf_rdy1_rst", 32'(req1_rdy), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mf_en0", 32'(rf_wrt_en), 32'd0);
        checkOutput("mf_haz1", 32'(hazard1), 32'd0);
        checkOutput("mf_haz2", 32'(hazard2), 32'd0);
        checkOutput("mf_src", 32'(gnt_src), 32'd0);
        applyStimulus(1'b1, 4'h8, 32'h88, 1'b1, 4'h9, 32'h99);
        step();
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("mf_en1", 32'(rf_wrt_en), 32'd0);
        checkOutput("mf_rdy0", 32'(req0_rdy), 32'd1);
        checkOutput("mf_rdy1", 32'(req1_rdy), 32'd0);
        step();
        @(negedge clk);
        checkOutput("mf_en2", 32'(rf_wrt_en), 32'd1);
        checkOutput("mf_src2", 32'(gnt_src), 32'd0);
        checkOutput("mf_sel2", 32'(rf_wrt_sel), 32'h8);
        checkOutput("mf_data2", rf_wrt_data, 32'h88);
        step();
        @(negedge clk);
        checkOutput("mf_src3", 32'(gnt_src), 32'd1);
        checkOutput("mf_sel3", 32'(rf_wrt_sel), 32'h9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
